// File: rtl/regfile_scoreboard_if.sv
// Bundle for the register file / scoreboard: write-back port, decode read
// ports, issue request and hazard/status outputs.
// "master" drives the pipeline side (write-back and decode stages).
// "slave" is the register file itself.
interface regfile_scoreboard_if;
    logic        Reg_Write_flag_In;
    logic [4:0]  Dest_Reg_Addr_In;
    logic [31:0] Data_In;
    logic [4:0]  Rs1_Addr_In;
    logic [4:0]  Rs2_Addr_In;
    logic [31:0] Rs1_Data_Out;
    logic [31:0] Rs2_Data_Out;
    logic        Issue_Valid_In;
    logic [4:0]  Issue_Rd_In;
    logic        Issue_Writes_In;
    logic        Stall_Out;
    logic [31:0] Busy_Vector_Out;
    logic [5:0]  Pending_Count_Out;

    modport master (
        output Reg_Write_flag_In, Dest_Reg_Addr_In, Data_In,
        output Rs1_Addr_In, Rs2_Addr_In,
        output Issue_Valid_In, Issue_Rd_In, Issue_Writes_In,
        input  Rs1_Data_Out, Rs2_Data_Out,
        input  Stall_Out, Busy_Vector_Out, Pending_Count_Out
    );

    modport slave (
        input  Reg_Write_flag_In, Dest_Reg_Addr_In, Data_In,
        input  Rs1_Addr_In, Rs2_Addr_In,
        input  Issue_Valid_In, Issue_Rd_In, Issue_Writes_In,
        output Rs1_Data_Out, Rs2_Data_Out,
        output Stall_Out, Busy_Vector_Out, Pending_Count_Out
    );
endinterface

// File: rtl/regfile_scoreboard.sv
// 32 x 32-bit register file with a pending-write scoreboard.
// x0 is hard-wired to zero and can never be marked busy.
// Optional macro RF_BYPASS_EN: a write-back in flight is forwarded to the
// read ports in the same cycle, and its register counts as not busy when the
// stall is computed. Without the macro, a hazard clears one cycle after the
// write-back.
module regfile_scoreboard (
    input  logic               Clk,
    input  logic               Rst_n,
    regfile_scoreboard_if.slave bus
);

    logic [31:0] regs_r [0:31];
    logic [31:0] busy_r;
    logic [5:0]  count_r;

    logic        wb_hit_s;
    logic [31:0] wb_mask_s;
    logic [31:0] busy_eff_s;
    logic        stall_s;
    logic        accept_s;
    logic [31:0] set_mask_s;
    logic [31:0] clr_mask_s;
    logic [31:0] busy_next_s;
    logic        set_new_s;
    logic        clr_net_s;
    logic [5:0]  count_next_s;
    logic [31:0] rd1_s;
    logic [31:0] rd2_s;

    // Hazard detection: effective busy bits (bypass-aware) and the stall
    always_comb begin
        wb_hit_s = bus.Reg_Write_flag_In && (bus.Dest_Reg_Addr_In != 5'd0);
`ifdef RF_BYPASS_EN
        if (wb_hit_s) begin
            wb_mask_s = 32'd1 << bus.Dest_Reg_Addr_In;
        end else begin
            wb_mask_s = 32'd0;
        end
`else
        wb_mask_s = 32'd0;
`endif
        busy_eff_s = busy_r & ~wb_mask_s;
        stall_s = Rst_n && bus.Issue_Valid_In &&
                  (busy_eff_s[bus.Rs1_Addr_In] || busy_eff_s[bus.Rs2_Addr_In] ||
                   (bus.Issue_Writes_In && busy_eff_s[bus.Issue_Rd_In]));
        accept_s = bus.Issue_Valid_In && !stall_s;
    end

    // Scoreboard next state: set on accepted issue wins over a same-register clear
    always_comb begin
        if (accept_s && bus.Issue_Writes_In && (bus.Issue_Rd_In != 5'd0)) begin
            set_mask_s = 32'd1 << bus.Issue_Rd_In;
        end else begin
            set_mask_s = 32'd0;
        end
        if (wb_hit_s) begin
            clr_mask_s = 32'd1 << bus.Dest_Reg_Addr_In;
        end else begin
            clr_mask_s = 32'd0;
        end
        busy_next_s = (busy_r & ~clr_mask_s) | set_mask_s;
        // Count only bits that actually change so the count tracks popcount
        set_new_s = |(set_mask_s & ~busy_r);
        clr_net_s = |(clr_mask_s & busy_r & ~set_mask_s);
        case ({set_new_s, clr_net_s})
            2'b10:   count_next_s = count_r + 6'd1;
            2'b01:   count_next_s = count_r - 6'd1;
            default: count_next_s = count_r;
        endcase
    end

    // Read ports: zero for x0 and during reset, optional same-cycle forwarding
    always_comb begin
        rd1_s = 32'd0;
        rd2_s = 32'd0;
        if (!Rst_n) begin
            rd1_s = 32'd0;
            rd2_s = 32'd0;
        end else begin
            if (bus.Rs1_Addr_In == 5'd0) begin
                rd1_s = 32'd0;
`ifdef RF_BYPASS_EN
            end else if (wb_hit_s && (bus.Dest_Reg_Addr_In == bus.Rs1_Addr_In)) begin
                rd1_s = bus.Data_In;
`endif
            end else begin
                rd1_s = regs_r[bus.Rs1_Addr_In];
            end
            if (bus.Rs2_Addr_In == 5'd0) begin
                rd2_s = 32'd0;
`ifdef RF_BYPASS_EN
            end else if (wb_hit_s && (bus.Dest_Reg_Addr_In == bus.Rs2_Addr_In)) begin
                rd2_s = bus.Data_In;
`endif
            end else begin
                rd2_s = regs_r[bus.Rs2_Addr_In];
            end
        end
    end

    // Register storage: write-back port, x0 writes discarded
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            for (int i = 0; i < 32; i++) begin
                regs_r[i] <= 32'd0;
            end
        end else if (wb_hit_s) begin
            regs_r[bus.Dest_Reg_Addr_In] <= bus.Data_In;
        end
    end

    // Scoreboard state: busy bits and pending-write count
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            busy_r  <= 32'd0;
            count_r <= 6'd0;
        end else begin
            busy_r  <= busy_next_s;
            count_r <= count_next_s;
        end
    end

    assign bus.Rs1_Data_Out      = rd1_s;
    assign bus.Rs2_Data_Out      = rd2_s;
    assign bus.Stall_Out         = stall_s;
    assign bus.Busy_Vector_Out   = busy_r;
    assign bus.Pending_Count_Out = count_r;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench for regfile_scoreboard. Expected values are queued when the
// stimulus is driven and popped when the corresponding output is sampled.
// Behaviour under RF_BYPASS_EN follows the same macro as the design build.
module tb_regfile_scoreboard;

    logic Clk;
    logic Rst_n;

    regfile_scoreboard_if bus ();

    regfile_scoreboard dut (
        .Clk   (Clk),
        .Rst_n (Rst_n),
        .bus   (bus)
    );

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t sb_q[$];
    int   n_cmp;
    int   n_fail;

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic drive_idle();
        bus.Reg_Write_flag_In = 1'b0;
        bus.Dest_Reg_Addr_In  = 5'd0;
        bus.Data_In           = 32'd0;
        bus.Rs1_Addr_In       = 5'd0;
        bus.Rs2_Addr_In       = 5'd0;
        bus.Issue_Valid_In    = 1'b0;
        bus.Issue_Rd_In       = 5'd0;
        bus.Issue_Writes_In   = 1'b0;
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic push(input string tag, input logic [31:0] val);
        exp_t e;
        e.tag = tag;
        e.val = val;
        sb_q.push_back(e);
    endtask

    task automatic pop_cmp(input logic [31:0] obs);
        exp_t e;
        n_cmp++;
        if (sb_q.size() == 0) begin
            n_fail++;
            $error("FAIL scoreboard_underflow observed=%h expected=<none>", obs);
        end else begin
            e = sb_q.pop_front();
            assert (obs === e.val) else begin
                n_fail++;
                $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.val);
            end
        end
    endtask

    task automatic issue(input logic [4:0] rd);
        drive_idle();
        bus.Issue_Valid_In  = 1'b1;
        bus.Issue_Writes_In = 1'b1;
        bus.Issue_Rd_In     = rd;
    endtask

    task automatic wb(input logic [4:0] rd, input logic [31:0] data);
        bus.Reg_Write_flag_In = 1'b1;
        bus.Dest_Reg_Addr_In  = rd;
        bus.Data_In           = data;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        drive_idle();
        Rst_n = 1'b0;

        // Reset: activity on the bus must have no effect while Rst_n is low
        bus.Issue_Valid_In  = 1'b1;
        bus.Issue_Writes_In = 1'b1;
        bus.Issue_Rd_In     = 5'd5;
        bus.Rs1_Addr_In     = 5'd5;
        wb(5'd5, 32'hDEAD_BEEF);
        push("rst_busy", 32'd0);
        push("rst_count", 32'd0);
        push("rst_stall", 32'd0);
        push("rst_rd1", 32'd0);
        #12;
        pop_cmp(bus.Busy_Vector_Out);
        pop_cmp(32'(bus.Pending_Count_Out));
        pop_cmp(32'(bus.Stall_Out));
        pop_cmp(bus.Rs1_Data_Out);
        @(negedge Clk);
        drive_idle();
        Rst_n = 1'b1;

        // Basic write/read and x0 behaviour
        wb(5'd5, 32'h0000_00AA);
        tick();
        drive_idle();
        bus.Rs1_Addr_In = 5'd5;
        push("x5_read", 32'h0000_00AA);
        #1 pop_cmp(bus.Rs1_Data_Out);
        drive_idle();
        wb(5'd0, 32'hFFFF_FFFF);
        bus.Rs2_Addr_In = 5'd0;
        push("x0_during_wb", 32'd0);
        #1 pop_cmp(bus.Rs2_Data_Out);
        tick();
        drive_idle();
        bus.Rs2_Addr_In = 5'd0;
        push("x0_read", 32'd0);
        #1 pop_cmp(bus.Rs2_Data_Out);

        // Issue x7, then a reader of x7 stalls
        issue(5'd7);
        push("issue7_stall", 32'd0);
        #1 pop_cmp(32'(bus.Stall_Out));
        tick();
        drive_idle();
        bus.Issue_Valid_In = 1'b1;
        bus.Rs1_Addr_In    = 5'd7;
        push("raw7_stall", 32'd1);
        push("raw7_busy", 32'h0000_0080);
        push("raw7_count", 32'd1);
        #1;
        pop_cmp(32'(bus.Stall_Out));
        pop_cmp(bus.Busy_Vector_Out);
        pop_cmp(32'(bus.Pending_Count_Out));

        // Write-back x7 while it is being read
        wb(5'd7, 32'h0000_1234);
`ifdef RF_BYPASS_EN
        push("wb7_stall", 32'd0);
        push("wb7_rd1", 32'h0000_1234);
`else
        push("wb7_stall", 32'd1);
        push("wb7_rd1", 32'd0);
`endif
        #1;
        pop_cmp(32'(bus.Stall_Out));
        pop_cmp(bus.Rs1_Data_Out);
        tick();
        drive_idle();
        bus.Issue_Valid_In = 1'b1;
        bus.Rs1_Addr_In    = 5'd7;
        push("post_wb7_stall", 32'd0);
        push("post_wb7_rd1", 32'h0000_1234);
        push("post_wb7_busy", 32'd0);
        push("post_wb7_count", 32'd0);
        #1;
        pop_cmp(32'(bus.Stall_Out));
        pop_cmp(bus.Rs1_Data_Out);
        pop_cmp(bus.Busy_Vector_Out);
        pop_cmp(32'(bus.Pending_Count_Out));

        // Same-edge set and clear of x3
        issue(5'd3);
        tick();
        drive_idle();
        push("x3_busy", 32'h0000_0008);
        push("x3_count", 32'd1);
        pop_cmp(bus.Busy_Vector_Out);
        pop_cmp(32'(bus.Pending_Count_Out));
        issue(5'd3);
        wb(5'd3, 32'h0000_0033);
`ifdef RF_BYPASS_EN
        push("setclr_stall", 32'd0);
`else
        push("setclr_stall", 32'd1);
`endif
        #1 pop_cmp(32'(bus.Stall_Out));
        tick();
        drive_idle();
`ifdef RF_BYPASS_EN
        push("setclr_busy", 32'h0000_0008);
        push("setclr_count", 32'd1);
`else
        push("setclr_busy", 32'd0);
        push("setclr_count", 32'd0);
`endif
        pop_cmp(bus.Busy_Vector_Out);
        pop_cmp(32'(bus.Pending_Count_Out));

        // Write-back of x3 again (clears if busy, no count change if not)
        wb(5'd3, 32'h0000_0333);
        tick();
        drive_idle();
        bus.Rs1_Addr_In = 5'd3;
        push("x3_clean_busy", 32'd0);
        push("x3_clean_count", 32'd0);
        push("x3_clean_rd1", 32'h0000_0333);
        #1;
        pop_cmp(bus.Busy_Vector_Out);
        pop_cmp(32'(bus.Pending_Count_Out));
        pop_cmp(bus.Rs1_Data_Out);

        // Fill every register x1..x31
        for (int i = 1; i < 32; i++) begin
            issue(5'(i));
            tick();
            drive_idle();
            push($sformatf("fill_count_%0d", i), 32'(i));
            pop_cmp(32'(bus.Pending_Count_Out));
        end
        push("full_busy", 32'hFFFF_FFFE);
        pop_cmp(bus.Busy_Vector_Out);

        // No stall without a valid issue, even with everything busy
        bus.Issue_Valid_In  = 1'b0;
        bus.Issue_Writes_In = 1'b1;
        bus.Issue_Rd_In     = 5'd9;
        bus.Rs1_Addr_In     = 5'd5;
        bus.Rs2_Addr_In     = 5'd7;
        push("novalid_stall", 32'd0);
        #1 pop_cmp(32'(bus.Stall_Out));
        bus.Issue_Valid_In = 1'b1;
        push("valid_full_stall", 32'd1);
        #1 pop_cmp(32'(bus.Stall_Out));

        // Drain every register
        for (int i = 1; i < 32; i++) begin
            drive_idle();
            wb(5'(i), 32'(i) * 32'h0101_0101);
            tick();
            drive_idle();
            push($sformatf("drain_count_%0d", i), 32'(31 - i));
            pop_cmp(32'(bus.Pending_Count_Out));
        end
        bus.Rs1_Addr_In = 5'd31;
        bus.Rs2_Addr_In = 5'd17;
        push("drain_busy", 32'd0);
        push("x31_read", 32'h1F1F_1F1F);
        push("x17_read", 32'h1111_1111);
        #1;
        pop_cmp(bus.Busy_Vector_Out);
        pop_cmp(bus.Rs1_Data_Out);
        pop_cmp(bus.Rs2_Data_Out);

        // Mid-cycle reset pulse with four busy registers
        issue(5'd2); tick();
        issue(5'd4); tick();
        issue(5'd6); tick();
        issue(5'd8); tick();
        drive_idle();
        push("four_count", 32'd4);
        pop_cmp(32'(bus.Pending_Count_Out));
        bus.Issue_Valid_In = 1'b1;
        bus.Rs1_Addr_In    = 5'd31;
        bus.Rs2_Addr_In    = 5'd2;
        @(posedge Clk);
        #2;
        Rst_n = 1'b0;
        push("async_busy", 32'd0);
        push("async_count", 32'd0);
        push("async_rd1", 32'd0);
        push("async_stall", 32'd0);
        #1;
        pop_cmp(bus.Busy_Vector_Out);
        pop_cmp(32'(bus.Pending_Count_Out));
        pop_cmp(bus.Rs1_Data_Out);
        pop_cmp(32'(bus.Stall_Out));

        // Traffic on the first edge after reset release takes effect
        issue(5'd10);
        wb(5'd9, 32'h0000_0055);
        @(negedge Clk);
        Rst_n = 1'b1;
        tick();
        drive_idle();
        bus.Rs1_Addr_In = 5'd9;
        bus.Rs2_Addr_In = 5'd31;
        push("resume_busy", 32'h0000_0400);
        push("resume_count", 32'd1);
        push("resume_x9", 32'h0000_0055);
        push("resume_x31", 32'd0);
        #1;
        pop_cmp(bus.Busy_Vector_Out);
        pop_cmp(32'(bus.Pending_Count_Out));
        pop_cmp(bus.Rs1_Data_Out);
        pop_cmp(bus.Rs2_Data_Out);

        // Every queued expectation must have been consumed
        n_cmp++;
        assert (sb_q.size() == 0) else begin
            n_fail++;
            $error("FAIL sb_leftover observed=%0d expected=0", sb_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
